alu_uart_sequencer: RTL and testbench

Transaction controller between the UART receiver/transmitter and the ALU. It collects tagged 10-bit frames from UART RX into operand/opcode registers that drive the combinational ALU. Once all three fields are present, it captures the ALU result and hands it to UART TX through a start/done handshake. It replaces ad-hoc frame decoding with one registered FSM that owns the whole request/response cycle.

---
 rtl/alu_uart_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - UART frame collector / ALU request-response sequencer
// Optional partial-collection timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer #(
  parameter int NB_OP          = 6,
  parameter int NB_DATA        = 8,
  parameter int NB_FULL_DATA   = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NB_FULL_DATA-1:0] i_rx_data,
  input  logic                    i_rx_done,
  input  logic [NB_DATA-1:0]      i_alu_result,
  input  logic                    i_tx_done,
  output logic [NB_DATA-1:0]      o_operand1,
  output logic [NB_DATA-1:0]      o_operand2,
  output logic [NB_OP-1:0]        o_opcode,
  output logic [NB_DATA-1:0]      o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_frame_err,
  output logic                    o_overrun
);

  typedef enum logic [1:0] {COLLECT, EXEC, SEND, WAIT_TX} state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] operand1_q, operand1_d;
  logic [NB_DATA-1:0] operand2_q, operand2_d;
  logic [NB_OP-1:0]   opcode_q, opcode_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               f1_q, f1_d;
  logic               f2_q, f2_d;
  logic               f3_q, f3_d;

  logic [1:0]         rx_tag;
  logic [NB_DATA-1:0] rx_payload;

  assign rx_tag     = i_rx_data[NB_DATA+1:NB_DATA];
  assign rx_payload = i_rx_data[NB_DATA-1:0];

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    opcode_d    = opcode_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    f1_d        = f1_q;
    f2_d        = f2_q;
    f3_d        = f3_q;

    case (state_q)
      COLLECT: begin
        if (i_rx_done) begin
          case (rx_tag)
            2'b00: begin
              operand1_d = rx_payload;
              f1_d       = 1'b1;
            end
            2'b01: begin
              operand2_d = rx_payload;
              f2_d       = 1'b1;
            end
            2'b10: begin
              opcode_d = rx_payload[NB_OP-1:0];
              f3_d     = 1'b1;
            end
            default: frame_err_d = 1'b1;
          endcase
          // Move on the same edge that stores the last missing field.
          if (f1_d && f2_d && f3_d) begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        f1_d       = 1'b0;
        f2_d       = 1'b0;
        f3_d       = 1'b0;
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (i_rx_done && (state_q != COLLECT)) begin
      overrun_d = 1'b1;
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_d = cnt_q;
    if (i_rx_done) begin
      cnt_d = '0;
    end else if ((state_q == COLLECT) && (f1_q || f2_q || f3_q)) begin
      // Stale partial collection: forget the fields but keep register contents.
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        f1_d  = 1'b0;
        f2_d  = 1'b0;
        f3_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != COLLECT);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= COLLECT;
      operand1_q  <= '0;
      operand2_q  <= '0;
      opcode_q    <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      f1_q        <= 1'b0;
      f2_q        <= 1'b0;
      f3_q        <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      opcode_q    <= opcode_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      f3_q        <= f3_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_operand1  = operand1_q;
  assign o_operand2  = operand2_q;
  assign o_opcode    = opcode_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb/tb_alu_uart_sequencer.sv - self-checking bench for alu_uart_sequencer
module tb_alu_uart_sequencer;
  localparam int TB_TO = 16;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [9:0] i_rx_data = '0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_alu_result;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_operand1, o_operand2, o_tx_data;
  logic [5:0] o_opcode;
  logic       o_tx_start, o_busy, o_frame_err, o_overrun;

  int vectors = 0;
  int miscompares = 0;
  int tx_seen = 0;

  // Transaction-level model of what the sequencer should hold.
  logic [7:0] m_op1, m_op2, m_tx_data;
  logic [5:0] m_opc;
  bit         m_have1, m_have2, m_have3;
  bit         m_busy;
  int         m_tx_cnt;
  int         m_idle;

  alu_uart_sequencer #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
    .o_operand1(o_operand1), .o_operand2(o_operand2), .o_opcode(o_opcode),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy),
    .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h02:   return a >> b[2:0];
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_fn(o_operand1, o_operand2, o_opcode);

  always @(posedge i_clk) if (!i_reset && o_tx_start) tx_seen++;

`ifdef ALU_SEQ_TIMEOUT_EN
  always @(posedge i_clk) begin
    if (i_reset || i_rx_done) m_idle = 0;
    else if (!m_busy && (m_have1 || m_have2 || m_have3)) begin
      m_idle++;
      if (m_idle == TB_TO) begin
        m_have1 = 0; m_have2 = 0; m_have3 = 0; m_idle = 0;
      end
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_op1 = 0; m_op2 = 0; m_opc = 0; m_tx_data = 0;
    m_have1 = 0; m_have2 = 0; m_have3 = 0; m_busy = 0; m_idle = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".op1"}, 32'(o_operand1), 32'(m_op1));
    check({tag, ".op2"}, 32'(o_operand2), 32'(m_op2));
    check({tag, ".opc"}, 32'(o_opcode), 32'(m_opc));
  endtask

  task automatic send_frame(input logic [9:0] f);
    bit fire = 0, exp_fe = 0, exp_ov = 0;
    logic [7:0] exp_r;
    @(negedge i_clk);
    i_rx_data = f; i_rx_done = 1'b1;
    if (m_busy) exp_ov = 1;
    else begin
      case (f[9:8])
        2'd0: begin m_op1 = f[7:0]; m_have1 = 1; end
        2'd1: begin m_op2 = f[7:0]; m_have2 = 1; end
        2'd2: begin m_opc = f[5:0]; m_have3 = 1; end
        default: exp_fe = 1;
      endcase
      fire = m_have1 && m_have2 && m_have3;
    end
    @(negedge i_clk);
    i_rx_done = 1'b0;
    check_regs("frame");
    check("frame.frame_err", 32'(o_frame_err), 32'(exp_fe));
    check("frame.overrun", 32'(o_overrun), 32'(exp_ov));
    check("frame.busy", 32'(o_busy), 32'(m_busy | fire));
    check("frame.tx_start_early", 32'(o_tx_start), 0);
    if (m_busy) check("frame.tx_data_hold", 32'(o_tx_data), 32'(m_tx_data));
    if (fire) begin
      m_have1 = 0; m_have2 = 0; m_have3 = 0;
      exp_r = alu_fn(m_op1, m_op2, m_opc);
      @(negedge i_clk);
      check("tx.start", 32'(o_tx_start), 1);
      check("tx.data", 32'(o_tx_data), 32'(exp_r));
      check("tx.busy", 32'(o_busy), 1);
      m_tx_cnt++; m_busy = 1; m_tx_data = exp_r;
    end
    @(negedge i_clk);
    check("after.tx_start", 32'(o_tx_start), 0);
    check("after.frame_err", 32'(o_frame_err), 0);
    check("after.overrun", 32'(o_overrun), 0);
    check("after.busy", 32'(o_busy), 32'(m_busy));
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clk);
    i_tx_done = 1'b1;
    @(negedge i_clk);
    i_tx_done = 1'b0;
    m_busy = 0;
    check("txdone.busy", 32'(o_busy), 0);
    check("txdone.tx_data", 32'(o_tx_data), 32'(m_tx_data));
  endtask

  task automatic check_tx_count(input string tag);
    check(tag, 32'(tx_seen), 32'(m_tx_cnt));
  endtask

  initial begin
    logic [9:0] q[$];
    logic [9:0] tmp;
    int j;
    model_reset();
    m_tx_cnt = 0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check_regs("reset");
    check("reset.tx_data", 32'(o_tx_data), 0);
    check("reset.busy", 32'(o_busy), 0);
    check("reset.tx_start", 32'(o_tx_start), 0);

    // Basic ADD transaction: 5 + 3.
    send_frame(10'h005); send_frame(10'h103); send_frame(10'h220);
    check("add.result_const", 32'(o_tx_data), 32'h08);
    tx_done_pulse();

    // Repeated operand1; last write wins.
    send_frame(10'h220); send_frame(10'h0FF); send_frame(10'h002); send_frame(10'h101);
    check_tx_count("dup.tx_count");

    // Overrun during WAIT_TX, then only two fields after release.
    send_frame(10'h011);
    tx_done_pulse();
    send_frame(10'h3AA);
    send_frame(10'h1AB); send_frame(10'h224);
    check_tx_count("partial.no_tx");
    tx_done_pulse();
    send_frame(10'h0C3);
    check_tx_count("partial.completes");
    tx_done_pulse();

    // Reset during SEND suppresses the start pulse.
    send_frame(10'h005); send_frame(10'h103);
    @(negedge i_clk);
    i_rx_data = 10'h220; i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
    check("rst.busy_exec", 32'(o_busy), 1);
    @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    model_reset();
    check_regs("rst_async");
    check("rst_async.tx_start", 32'(o_tx_start), 0);
    check("rst_async.busy", 32'(o_busy), 0);
    check("rst_async.tx_data", 32'(o_tx_data), 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    check_tx_count("rst.no_tx");
    send_frame(10'h10A); send_frame(10'h222); send_frame(10'h02F);
    tx_done_pulse();
    check_tx_count("rst.recover");

`ifdef ALU_SEQ_TIMEOUT_EN
    send_frame(10'h005);
    repeat (TB_TO) @(negedge i_clk);
    send_frame(10'h103); send_frame(10'h220);
    check_tx_count("timeout.no_tx");
    send_frame(10'h007);
    check_tx_count("timeout.tx");
    tx_done_pulse();
`endif

    // Randomized transactions with shuffled fields, bad tags and duplicates.
    for (int t = 0; t < 40; t++) begin
      q.delete();
      q.push_back({2'b00, 8'($urandom)});
      q.push_back({2'b01, 8'($urandom)});
      q.push_back({2'b10, 8'($urandom_range(0, 7) == 0 ? 8'h20 : 8'($urandom))});
      if ($urandom_range(0, 3) == 0) q.push_back({2'b11, 8'($urandom)});
      if ($urandom_range(0, 3) == 0) q.push_back({2'($urandom_range(0, 2)), 8'($urandom)});
      for (int k = q.size() - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = q[k]; q[k] = q[j]; q[j] = tmp;
      end
      foreach (q[k]) begin
        send_frame(q[k]);
        repeat ($urandom_range(0, 2)) @(negedge i_clk);
      end
      if ($urandom_range(0, 2) == 0) send_frame(10'($urandom));
      tx_done_pulse();
      check_tx_count("rand.tx_count");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
